bcd_freq_synth: RTL and testbench
=================================

// Module: bcd_freq_synth
// PURPOSE
// Programmable test-frequency source, the generating end of the frequency-meter path.
// Divides the reference clock input_clk by an 8-digit BCD divisor N.
// Emits a 1-cycle strobe every N cycles and a 50% square wave of F(input_clk)/(2N).
// Its output drives the meter's input pin, so the meter reading checks it directly.
// PARAMETERS
// DIGITS       8   number of BCD digits in the divisor and counter
// DEFAULT_DIV  2   divisor after reset, as an integer; converted to BCD at elaboration
// PORTS
// input_clk   in   1          reference clock; all logic on its rising edge
// reset       in   1          asynchronous, active-high
// div_bcd     in   4*DIGITS   requested divisor N, packed BCD, digit 0 = LSD
// load        in   1          1-cycle request to capture div_bcd
// enable      in   1          1 = run, 0 = idle
// load_ack    out  1          1-cycle pulse, cycle after load: div_bcd accepted into pending
// err_bcd     out  1          sticky error: invalid divisor requested; cleared by a valid load
// busy        out  1          1 while in RUN
// count_bcd   out  4*DIGITS   current down-counter value, packed BCD
// strobe      out  1          1-cycle pulse at each terminal count
// out_wave    out  1          square wave; toggles on every strobe
// BEHAVIOUR
// - Reset (async): all outputs 0; state IDLE; active and pending divisor = DEFAULT_DIV in BCD;
//   pend_valid = 0.
// - Validity rule: every digit <= 9 and N >= 2. Otherwise the request is invalid.
// - Invalid load: err_bcd = 1 next cycle; no load_ack; active and pending divisors unchanged.
// - Valid load: pending <= div_bcd, pend_valid = 1, load_ack = 1 and err_bcd = 0 next cycle.
//   A later load overwrites pending.
// - States:
//   - IDLE: count_bcd = 0, strobe = 0, out_wave = 0.
//     - enable = 1 -> RUN. Active <= pending if pend_valid (pend_valid cleared).
//       Count <= active N.
//   - RUN: count decrements by 1 per cycle (BCD, borrow chained LSD to MSD).
//     - When count == 1: strobe = 1 that cycle; out_wave toggles; count <= N (reload).
//     - Strobe period is exactly N cycles.
//     - enable = 0 -> IDLE next cycle; out_wave, strobe and count go to 0; no partial strobe.
// - Divisor change while RUN: takes effect at the reload after the next strobe.
//   It is never applied mid-period, so the output stays glitch-free.
//   At that strobe, active <= pending and count <= new N; pend_valid is cleared.
// - Simultaneous load and terminal count in one cycle: the reload uses the old active N.
//   The new value is applied at the following terminal.
// - Arithmetic: no binary conversion. Per-digit decrement: 0 with borrow-in -> 9 and borrow-out.
//   Count never reaches 0 in RUN, so there is no underflow.
// - Reset mid-RUN: immediate return to reset values; pending requests are discarded.
// - busy = (state == RUN), registered.
// STRUCTURE
// - Shared package, freq_meter_pkg:
//   - BCD_W = 4, BCD_MAX = 4'd9
//   - typedef of the packed DIGITS-wide BCD word
//   - function bcd_valid()
//   - function int_to_bcd() for DEFAULT_DIV
// - Sub-module bcd_digit_dec: one digit.
//   - Inputs: load, load_val, dec_en (= borrow-in).
//   - Outputs: digit, borrow_out, is_zero.
//   - Instantiate DIGITS times in a borrow chain.
// - Top level holds the FSM, the active/pending registers, the validity check and out_wave.
// TESTING
// - N=00000002, enable=1: strobe every 2 cycles; out_wave period 4 cycles, 50% duty; busy=1.
// - N=00000010: count_bcd sequence 10,09,08..01,10. Digit-1 borrow visible; strobe period 10.
// - N=10000000: one cycle after entering RUN, count_bcd=09999999 (full borrow chain).
// - load div_bcd=0000000A, then separately 00000001: err_bcd=1 each time, no load_ack,
//   period unchanged. Then load 00000003: err_bcd=0 and load_ack pulses.
// - RUN N=5, load N=3 mid-period: current period stays 5 cycles, next periods 3.
//   Repeat with the load in the strobe cycle: one more period of 5, then 3.
// - Mid-RUN: drop enable -> out_wave=0, busy=0 next cycle. Assert reset asynchronously ->
//   all outputs 0 before the next edge; after release and enable, period = DEFAULT_DIV.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency-meter path.
// Contents:
//   BCD_W, BCD_MAX, BCD_DIGITS  digit width, largest legal digit, digits per word
//   bcd_word_t                  packed BCD word, digit 0 in bits [3:0]
//   synth_state_t               state encoding of the frequency synthesiser
//   bcd_valid()                 1 if every digit <= 9 and the value is >= 2
//   int_to_bcd()                integer to packed BCD, for elaboration-time constants
package freq_meter_pkg;

  localparam int              BCD_W      = 4;
  localparam logic [BCD_W-1:0] BCD_MAX    = 4'd9;
  localparam int              BCD_DIGITS = 8;

  typedef logic [BCD_DIGITS*BCD_W-1:0] bcd_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } synth_state_t;

  // A divisor is usable when it is proper BCD and at least 2; a divisor of
  // 1 would need the terminal count and the reload in the same cycle.
  function automatic logic bcd_valid(input bcd_word_t w);
    logic             digits_ok;
    logic             upper_nonzero;
    logic [BCD_W-1:0] d;
    digits_ok     = 1'b1;
    upper_nonzero = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      d = w[i*BCD_W +: BCD_W];
      if (d > BCD_MAX) digits_ok = 1'b0;
      if ((i > 0) && (d != '0)) upper_nonzero = 1'b1;
    end
    return digits_ok && (upper_nonzero || (w[BCD_W-1:0] >= 4'd2));
  endfunction

  function automatic bcd_word_t int_to_bcd(input int value);
    bcd_word_t r;
    int        rem;
    r   = '0;
    rem = value;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      r[i*BCD_W +: BCD_W] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_freq_synth_if.sv
// Control/status bundle of the BCD frequency synthesiser.
// Signals:
//   div_bcd, load, enable                 requests from the controller
//   load_ack, err_bcd, busy               status back to the controller
//   count_bcd, strobe, out_wave           counter value and generated outputs
// Modports: master = controller side, slave = synthesiser side.
interface bcd_freq_synth_if;
  import freq_meter_pkg::*;

  bcd_word_t div_bcd;
  logic      load;
  logic      enable;
  logic      load_ack;
  logic      err_bcd;
  logic      busy;
  bcd_word_t count_bcd;
  logic      strobe;
  logic      out_wave;

  modport master (
    output div_bcd, load, enable,
    input  load_ack, err_bcd, busy, count_bcd, strobe, out_wave
  );

  modport slave (
    input  div_bcd, load, enable,
    output load_ack, err_bcd, busy, count_bcd, strobe, out_wave
  );

endinterface

// File: rtl/bcd_digit_dec.sv
// One decade of the BCD down-counter.
// Ports:
//   input_clk, reset   clock and asynchronous active-high reset
//   load, load_val     parallel load (has priority over decrement)
//   dec_en             decrement request, i.e. borrow in from the lower digit
//   digit              current digit value
//   borrow_out         borrow to the next digit: decrementing through zero
//   is_zero            digit currently holds 0
module bcd_digit_dec
  import freq_meter_pkg::*;
(
  input  logic             input_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec_en,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out,
  output logic             is_zero
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec_en) begin
      digit_d = (digit_q == '0) ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  assign digit      = digit_q;
  assign is_zero    = (digit_q == '0);
  assign borrow_out = dec_en && !load && (digit_q == '0);

endmodule

// File: rtl/bcd_freq_synth.sv
// Programmable test-frequency source: divides input_clk by a BCD divisor N,
// giving a one-cycle strobe every N cycles and a 50% square wave at F/(2N).
// Ports:
//   input_clk, reset   reference clock, asynchronous active-high reset
//   bus (slave)        div_bcd/load/enable in; load_ack, err_bcd, busy,
//                      count_bcd, strobe, out_wave out
// Parameters:
//   DIGITS       number of counter decades (the word width comes from the package)
//   DEFAULT_DIV  divisor in force after reset, as an integer
module bcd_freq_synth
  import freq_meter_pkg::*;
#(
  parameter int DIGITS      = BCD_DIGITS,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             input_clk,
  input  logic             reset,
  bcd_freq_synth_if.slave  bus
);

  localparam bcd_word_t DEFAULT_BCD = int_to_bcd(DEFAULT_DIV);

  synth_state_t state_q, state_d;
  bcd_word_t    active_q, active_d;
  bcd_word_t    pend_q, pend_d;
  logic         pend_valid_q, pend_valid_d;
  logic         load_ack_q, load_ack_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;
  logic         wave_q, wave_d;

  logic         div_ok;
  logic         count_is_one;
  logic         cnt_load;
  bcd_word_t    cnt_load_val;
  bcd_word_t    reload_val;
  bcd_word_t    count_w;
  logic [DIGITS:0]   dec_chain;
  logic [DIGITS-1:0] digit_zero;
  logic         chain_unused;

  // Counter decades: dec_chain[0] is the per-cycle decrement, each digit's
  // borrow feeds the next digit up.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit_dec u_digit (
      .input_clk  (input_clk),
      .reset      (reset),
      .load       (cnt_load),
      .load_val   (cnt_load_val[gi*BCD_W +: BCD_W]),
      .dec_en     (dec_chain[gi]),
      .digit      (count_w[gi*BCD_W +: BCD_W]),
      .borrow_out (dec_chain[gi+1]),
      .is_zero    (digit_zero[gi])
    );
  end

  // The MSD never borrows in RUN and the LSD zero flag is not needed for
  // terminal detection (the LSD is compared against 1 directly).
  assign chain_unused = dec_chain[DIGITS] ^ digit_zero[0];

  assign div_ok       = bcd_valid(bus.div_bcd);
  assign count_is_one = (count_w[BCD_W-1:0] == 4'd1) && (&digit_zero[DIGITS-1:1]);

  // Only the registered pending value is consulted, so a load arriving in
  // the terminal cycle itself waits for the following terminal.
  assign reload_val   = pend_valid_q ? pend_q : active_q;

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    load_ack_d   = 1'b0;
    err_d        = err_q;
    wave_d       = wave_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    dec_chain[0] = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d      = ST_RUN;
          cnt_load     = 1'b1;
          cnt_load_val = reload_val;
          active_d     = reload_val;
          pend_valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!bus.enable) begin
          // Abandon the period: counter and wave return to zero.
          state_d      = ST_IDLE;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
          wave_d       = 1'b0;
        end else if (count_is_one) begin
          wave_d       = ~wave_q;
          cnt_load     = 1'b1;
          cnt_load_val = reload_val;
          active_d     = reload_val;
          pend_valid_d = 1'b0;
        end else begin
          dec_chain[0] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load handling last so a fresh request survives a same-cycle hand-over.
    if (bus.load) begin
      if (div_ok) begin
        pend_d       = bus.div_bcd;
        pend_valid_d = 1'b1;
        load_ack_d   = 1'b1;
        err_d        = 1'b0;
      end else begin
        err_d        = 1'b1;
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      active_q     <= DEFAULT_BCD;
      pend_q       <= DEFAULT_BCD;
      pend_valid_q <= 1'b0;
      load_ack_q   <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      wave_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      load_ack_q   <= load_ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      wave_q       <= wave_d;
    end
  end

  assign bus.load_ack  = load_ack_q;
  assign bus.err_bcd   = err_q;
  assign bus.busy      = busy_q;
  assign bus.count_bcd = count_w;
  assign bus.strobe    = (state_q == ST_RUN) && count_is_one;
  assign bus.out_wave  = wave_q;

endmodule

// File: tb/tb_bcd_freq_synth.sv
// Directed testbench for bcd_freq_synth: default divisor, BCD borrow,
// full borrow chain, invalid loads, divisor changes and asynchronous reset.
module tb_bcd_freq_synth;
  import freq_meter_pkg::*;

  logic input_clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd_freq_synth_if bus ();

  bcd_freq_synth #(.DIGITS(8), .DEFAULT_DIV(2)) dut (
    .input_clk (input_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 input_clk = ~input_clk;

  // Advance to just after the next rising edge; all sampling happens here.
  task automatic tick();
    @(posedge input_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.load = 1'b0; bus.enable = 1'b0; bus.div_bcd = '0;
    repeat (3) tick();
    n_checks++; if (bus.count_bcd !== '0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", bus.count_bcd); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", bus.strobe); end
    n_checks++; if (bus.out_wave !== 1'b0) begin n_fail++; $display("FAIL reset_wave: got %b expected 0", bus.out_wave); end
    n_checks++; if (bus.load_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.load_ack); end
    n_checks++; if (bus.err_bcd !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err_bcd); end
    reset = 1'b0;
    tick();
    $display("reset released, outputs idle");
  endtask

  // Default divisor 2: count 2,1,..., strobe every 2, wave period 4.
  task automatic test_default_div2();
    logic [31:0] exp_cnt [7] = '{2, 1, 2, 1, 2, 1, 2};
    logic        exp_stb [7] = '{0, 1, 0, 1, 0, 1, 0};
    logic        exp_wav [7] = '{0, 0, 1, 1, 0, 0, 1};
    bus.enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++; if (bus.count_bcd !== exp_cnt[i]) begin n_fail++; $display("FAIL div2_count[%0d]: got %h expected %h", i, bus.count_bcd, exp_cnt[i]); end
      n_checks++; if (bus.strobe !== exp_stb[i]) begin n_fail++; $display("FAIL div2_strobe[%0d]: got %b expected %b", i, bus.strobe, exp_stb[i]); end
      n_checks++; if (bus.out_wave !== exp_wav[i]) begin n_fail++; $display("FAIL div2_wave[%0d]: got %b expected %b", i, bus.out_wave, exp_wav[i]); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL div2_busy[%0d]: got %b expected 1", i, bus.busy); end
    end
    // Drop enable while the wave is high.
    bus.enable = 1'b0;
    tick();
    n_checks++; if (bus.out_wave !== 1'b0) begin n_fail++; $display("FAIL drop_wave: got %b expected 0", bus.out_wave); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.count_bcd !== '0) begin n_fail++; $display("FAIL drop_count: got %h expected 0", bus.count_bcd); end
    n_checks++; if (bus.strobe !== 1'b0) begin n_fail++; $display("FAIL drop_strobe: got %b expected 0", bus.strobe); end
    $display("div2 run: 7 cycles then enable dropped");
  endtask

  // N=10: 10,09,...,01,10 with the tens digit borrowing.
  task automatic test_bcd_borrow();
    bcd_word_t exp;
    bus.div_bcd = 32'h0000_0010; bus.load = 1'b1;
    tick();
    $display("load %h -> ack=%b err=%b", bus.div_bcd, bus.load_ack, bus.err_bcd);
    n_checks++; if (bus.load_ack !== 1'b1) begin n_fail++; $display("FAIL n10_ack: got %b expected 1", bus.load_ack); end
    bus.load = 1'b0;
    tick();
    n_checks++; if (bus.load_ack !== 1'b0) begin n_fail++; $display("FAIL n10_ack_pulse: got %b expected 0", bus.load_ack); end
    bus.enable = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      exp = ((i == 0) || (i == 10)) ? 32'h0000_0010 : bcd_word_t'(10 - i);
      n_checks++; if (bus.count_bcd !== exp) begin n_fail++; $display("FAIL n10_count[%0d]: got %h expected %h", i, bus.count_bcd, exp); end
      n_checks++; if (bus.strobe !== (i == 9)) begin n_fail++; $display("FAIL n10_strobe[%0d]: got %b expected %b", i, bus.strobe, (i == 9)); end
    end
    bus.enable = 1'b0;
    tick();
    $display("n10 run: 11 cycles checked");
  endtask

  // N=10000000: the first decrement ripples through all eight digits.
  task automatic test_full_chain();
    bus.div_bcd = 32'h1000_0000; bus.load = 1'b1;
    tick();
    $display("load %h -> ack=%b err=%b", bus.div_bcd, bus.load_ack, bus.err_bcd);
    bus.load = 1'b0;
    bus.enable = 1'b1;
    tick();
    n_checks++; if (bus.count_bcd !== 32'h1000_0000) begin n_fail++; $display("FAIL chain_start: got %h expected 10000000", bus.count_bcd); end
    tick();
    n_checks++; if (bus.count_bcd !== 32'h0999_9999) begin n_fail++; $display("FAIL chain_borrow: got %h expected 09999999", bus.count_bcd); end
    n_checks++; if (bus.strobe !== 1'b0) begin n_fail++; $display("FAIL chain_strobe: got %b expected 0", bus.strobe); end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_invalid_load();
    logic [31:0] exp_cnt [5] = '{4, 3, 2, 1, 4};
    bus.div_bcd = 32'h0000_0004; bus.load = 1'b1;
    tick();
    $display("load %h -> ack=%b err=%b", bus.div_bcd, bus.load_ack, bus.err_bcd);
    bus.div_bcd = 32'h0000_000A;
    tick();
    $display("load %h -> ack=%b err=%b", bus.div_bcd, bus.load_ack, bus.err_bcd);
    n_checks++; if (bus.err_bcd !== 1'b1) begin n_fail++; $display("FAIL inv_a_err: got %b expected 1", bus.err_bcd); end
    n_checks++; if (bus.load_ack !== 1'b0) begin n_fail++; $display("FAIL inv_a_ack: got %b expected 0", bus.load_ack); end
    bus.div_bcd = 32'h0000_0001;
    tick();
    $display("load %h -> ack=%b err=%b", bus.div_bcd, bus.load_ack, bus.err_bcd);
    n_checks++; if (bus.err_bcd !== 1'b1) begin n_fail++; $display("FAIL inv_1_err: got %b expected 1", bus.err_bcd); end
    n_checks++; if (bus.load_ack !== 1'b0) begin n_fail++; $display("FAIL inv_1_ack: got %b expected 0", bus.load_ack); end
    bus.load = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus.count_bcd !== exp_cnt[i]) begin n_fail++; $display("FAIL inv_count[%0d]: got %h expected %h", i, bus.count_bcd, exp_cnt[i]); end
    end
    n_checks++; if (bus.err_bcd !== 1'b1) begin n_fail++; $display("FAIL inv_sticky: got %b expected 1", bus.err_bcd); end
    bus.enable = 1'b0;
    tick();
    bus.div_bcd = 32'h0000_0003; bus.load = 1'b1;
    tick();
    $display("load %h -> ack=%b err=%b", bus.div_bcd, bus.load_ack, bus.err_bcd);
    n_checks++; if (bus.err_bcd !== 1'b0) begin n_fail++; $display("FAIL inv_clear_err: got %b expected 0", bus.err_bcd); end
    n_checks++; if (bus.load_ack !== 1'b1) begin n_fail++; $display("FAIL inv_clear_ack: got %b expected 1", bus.load_ack); end
    bus.load = 1'b0;
    tick();
  endtask

  // Run N=5 and request N=3 in cycle load_at of the first period.
  task automatic run_change(input int load_at, input int len, input logic [31:0] exp_cnt [14], input string tag);
    bus.div_bcd = 32'h0000_0005; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      n_checks++; if (bus.count_bcd !== exp_cnt[i]) begin n_fail++; $display("FAIL %s_count[%0d]: got %h expected %h", tag, i, bus.count_bcd, exp_cnt[i]); end
      n_checks++; if (bus.strobe !== (exp_cnt[i] == 1)) begin n_fail++; $display("FAIL %s_strobe[%0d]: got %b expected %b", tag, i, bus.strobe, (exp_cnt[i] == 1)); end
      if (i == load_at + 1) begin
        n_checks++; if (bus.load_ack !== 1'b1) begin n_fail++; $display("FAIL %s_ack: got %b expected 1", tag, bus.load_ack); end
        bus.load = 1'b0;
      end
      if (i == load_at) begin
        bus.div_bcd = 32'h0000_0003; bus.load = 1'b1;
      end
    end
    bus.enable = 1'b0;
    tick();
    $display("%s: 5 -> 3 change, %0d cycles checked", tag, len);
  endtask

  task automatic test_change_mid_period();
    logic [31:0] exp_cnt [14] = '{5, 4, 3, 2, 1, 3, 2, 1, 3, 2, 1, 0, 0, 0};
    run_change(2, 11, exp_cnt, "mid");
  endtask

  task automatic test_change_at_strobe();
    logic [31:0] exp_cnt [14] = '{5, 4, 3, 2, 1, 5, 4, 3, 2, 1, 3, 2, 1, 3};
    run_change(4, 14, exp_cnt, "at_strobe");
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_cnt [4] = '{2, 1, 2, 1};
    bus.div_bcd = 32'h0000_0003; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.enable = 1'b1;
    repeat (4) tick();
    n_checks++; if (bus.out_wave !== 1'b1) begin n_fail++; $display("FAIL arst_pre_wave: got %b expected 1", bus.out_wave); end
    bus.div_bcd = 32'h0000_0007; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_checks++; if (bus.load_ack !== 1'b1) begin n_fail++; $display("FAIL arst_pre_ack: got %b expected 1", bus.load_ack); end
    #2 reset = 1'b1; bus.enable = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.count_bcd !== '0) begin n_fail++; $display("FAIL arst_count: got %h expected 0", bus.count_bcd); end
    n_checks++; if (bus.out_wave !== 1'b0) begin n_fail++; $display("FAIL arst_wave: got %b expected 0", bus.out_wave); end
    n_checks++; if (bus.load_ack !== 1'b0) begin n_fail++; $display("FAIL arst_ack: got %b expected 0", bus.load_ack); end
    n_checks++; if (bus.strobe !== 1'b0) begin n_fail++; $display("FAIL arst_strobe: got %b expected 0", bus.strobe); end
    #2 reset = 1'b0;
    tick();
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.count_bcd !== exp_cnt[i]) begin n_fail++; $display("FAIL arst_count[%0d]: got %h expected %h", i, bus.count_bcd, exp_cnt[i]); end
      n_checks++; if (bus.strobe !== (i % 2 == 1)) begin n_fail++; $display("FAIL arst_strobe[%0d]: got %b expected %b", i, bus.strobe, (i % 2 == 1)); end
    end
    bus.enable = 1'b0;
    tick();
    $display("async reset mid-run, default divisor restored");
  endtask

  initial begin
    test_reset();
    test_default_div2();
    test_bcd_borrow();
    test_full_chain();
    test_invalid_load();
    test_change_mid_period();
    test_change_at_strobe();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
